// File: rtl/tetris_pkg.sv
// Shared board constants, the line-clear sequencer state encoding and the
// per-clear score table. Used by line_clear_sequencer and row_popcount.
package tetris_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;
  localparam int ROW_W      = 5;

  typedef enum logic [2:0] {
    CLR_IDLE,
    CLR_SCAN,
    CLR_DRAIN,
    CLR_FILL,
    CLR_DONE
  } clr_state_e;

  localparam int          SCORE_W      = 20;
  localparam logic [19:0] LINE_SCORE_1 = 20'd40;
  localparam logic [19:0] LINE_SCORE_2 = 20'd100;
  localparam logic [19:0] LINE_SCORE_3 = 20'd300;
  localparam logic [19:0] LINE_SCORE_4 = 20'd1200;
  localparam logic [19:0] SCORE_MAX    = 20'hFFFFF;

  // Points awarded for one clear pass; four or more lines earn the top award.
  function automatic logic [19:0] line_score(input int unsigned lines);
    case (lines)
      0:       return '0;
      1:       return LINE_SCORE_1;
      2:       return LINE_SCORE_2;
      3:       return LINE_SCORE_3;
      default: return LINE_SCORE_4;
    endcase
  endfunction

endpackage

// File: rtl/row_popcount.sv
// Counts the set bits of a row mask. Purely combinational; also used by the
// game control for completed-line detection.
module row_popcount #(
  parameter int ROWS  = tetris_pkg::BOARD_ROWS,
  parameter int ROW_W = tetris_pkg::ROW_W
) (
  input  logic [ROWS-1:0]  mask,
  output logic [ROW_W-1:0] count
);

  // Ripple-add every mask bit into the count.
  always_comb begin
    count = '0;
    for (int i = 0; i < ROWS; i++) begin
      count = count + ROW_W'(mask[i]);
    end
  end

endmodule

// File: rtl/line_clear_sequencer.sv
// Removes the rows flagged in completed_lines from the board memory, compacts
// the survivors toward the bottom (row ROWS-1) and zero-fills the top.
// Optional build macro LINE_CLEAR_SCORE_EN adds a saturating score output.
module line_clear_sequencer
  import tetris_pkg::*;
#(
  parameter int ROWS  = BOARD_ROWS,
  parameter int COLS  = BOARD_COLS,
  parameter int ROW_W = tetris_pkg::ROW_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [ROWS-1:0]  completed_lines,
  output logic             busy,
  output logic             done,
  output logic [ROW_W-1:0] lines_cleared,
  output logic             rd_en,
  output logic [ROW_W-1:0] rd_addr,
  input  logic [COLS-1:0]  rd_data,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_addr,
  output logic [COLS-1:0]  wr_data
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [19:0]      score
`endif
);

  localparam logic [ROW_W-1:0] BOTTOM_ROW = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ONE        = ROW_W'(1);

  clr_state_e       state, state_nxt;
  logic [ROWS-1:0]  mask;
  logic [ROW_W-1:0] rd_ptr;
  logic [ROW_W-1:0] wr_ptr;
  logic [ROW_W-1:0] pipe_addr;
  logic             pipe_valid;
  logic [ROW_W-1:0] pop_count;

  row_popcount #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W)
  ) u_popcount (
    .mask  (completed_lines),
    .count (pop_count)
  );

  // Next-state decode and memory strobes; the write port defaults to the
  // pending copy issued by last cycle's read.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = pipe_valid;
    wr_addr   = pipe_valid ? pipe_addr : '0;
    wr_data   = pipe_valid ? rd_data : '0;
    unique case (state)
      CLR_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (completed_lines == '0) ? CLR_DONE : CLR_SCAN;
        end
      end
      CLR_SCAN: begin
        if (!mask[rd_ptr]) begin
          rd_en   = 1'b1;
          rd_addr = rd_ptr;
        end
        if (rd_ptr == '0) begin
          state_nxt = CLR_DRAIN;
        end
      end
      CLR_DRAIN: state_nxt = CLR_FILL;
      CLR_FILL: begin
        wr_en   = 1'b1;
        wr_addr = wr_ptr;
        wr_data = '0;
        if (wr_ptr == '0) begin
          state_nxt = CLR_DONE;
        end
      end
      CLR_DONE: begin
        done      = 1'b1;
        state_nxt = CLR_IDLE;
      end
      default: state_nxt = CLR_IDLE;
    endcase
  end

  // State, row pointers, latched mask and the one-deep read-to-write pipeline.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // here sees the pre-edge values of the others.
    if (reset) begin
      state         <= CLR_IDLE;
      mask          <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      pipe_valid    <= 1'b0;
      pipe_addr     <= '0;
      lines_cleared <= '0;
    end else begin
      state      <= state_nxt;
      pipe_valid <= rd_en;
      if (rd_en) begin
        pipe_addr <= wr_ptr;
      end
      unique case (state)
        CLR_IDLE: begin
          if (start) begin
            mask          <= completed_lines;
            lines_cleared <= pop_count;
            rd_ptr        <= BOTTOM_ROW;
            wr_ptr        <= BOTTOM_ROW;
          end
        end
        CLR_SCAN: begin
          rd_ptr <= rd_ptr - ONE;
          if (rd_en) begin
            wr_ptr <= wr_ptr - ONE;
          end
        end
        CLR_FILL: begin
          if (wr_ptr != '0) begin
            wr_ptr <= wr_ptr - ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [20:0] score_sum;

  assign score_sum = {1'b0, score} + {1'b0, line_score(32'(lines_cleared))};

  // Award points once per pass as the sequencer signals done, saturating.
  always_ff @(posedge clock) begin
    if (reset) begin
      score <= '0;
    end else if (state == CLR_DONE) begin
      score <= score_sum[20] ? SCORE_MAX : score_sum[19:0];
    end
  end
`endif

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Self-checking bench for line_clear_sequencer: a board memory model with
// 1-cycle read latency, a queue of expected writes built from a reference
// compaction of the board, and per-scenario checks of latency and results.
module tb_line_clear_sequencer;

  localparam int ROWS  = 20;
  localparam int COLS  = 10;
  localparam int ROW_W = 5;

  typedef struct packed {
    logic [ROW_W-1:0] addr;
    logic [COLS-1:0]  data;
  } wr_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [ROWS-1:0]  completed_lines = '0;
  logic             busy, done, rd_en, wr_en;
  logic [ROW_W-1:0] lines_cleared, rd_addr, wr_addr;
  logic [COLS-1:0]  rd_data, wr_data;
`ifdef LINE_CLEAR_SCORE_EN
  logic [19:0]      score;
  logic [19:0]      exp_score = '0;
`endif

  logic [COLS-1:0]  mem [ROWS];
  logic             ld_en = 1'b0;
  logic [ROW_W-1:0] ld_addr = '0;
  logic [COLS-1:0]  ld_data = '0;

  wr_t exp_q[$];
  wr_t exp_w;
  int  tests  = 0;
  int  fails  = 0;
  int  rd_cnt = 0;
  int  wr_cnt = 0;

  always #5 clock = ~clock;

  line_clear_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .completed_lines (completed_lines),
    .busy            (busy),
    .done            (done),
    .lines_cleared   (lines_cleared),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data)
`ifdef LINE_CLEAR_SCORE_EN
    ,
    .score           (score)
`endif
  );

  // Board storage: one read port with 1-cycle latency, one write port, and a
  // bench-only load port used while the sequencer is idle.
  always @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Scoreboard: every DUT write is popped against the expected write queue.
  always @(negedge clock) begin
    if (rd_en) rd_cnt++;
    if (wr_en) begin
      wr_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected: got addr %0d data %h, required no write", wr_addr, wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({wr_addr, wr_data} !== exp_w) begin
          fails++;
          $display("FAIL write_order: got addr %0d data %h, required addr %0d data %h",
                   wr_addr, wr_data, exp_w.addr, exp_w.data);
        end
      end
    end
  end

  function automatic logic [19:0] score_for(input int n);
    case (n)
      0:       return 20'd0;
      1:       return 20'd40;
      2:       return 20'd100;
      3:       return 20'd300;
      default: return 20'd1200;
    endcase
  endfunction

  task automatic load_row(input int r, input logic [COLS-1:0] d);
    @(negedge clock);
    ld_en   = 1'b1;
    ld_addr = ROW_W'(r);
    ld_data = d;
    @(negedge clock);
    ld_en   = 1'b0;
  endtask

  task automatic load_board(input int seed);
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clock);
      ld_en   = 1'b1;
      ld_addr = ROW_W'(r);
      ld_data = COLS'((seed * 97 + r * 29 + 7) % 1024);
    end
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  // One clear pass: build expected board and write stream, pulse start, wait
  // (bounded) for done, then check latency, counts, board and count outputs.
  // disturb re-asserts start with a different mask mid-SCAN; abort_at > 0
  // asserts reset at that cycle after start instead of completing the pass.
  task automatic run_pass(input string name, input logic [ROWS-1:0] m,
                          input bit disturb, input int abort_at);
    logic [COLS-1:0] exp_board [ROWS];
    int  wp, lc, lat, exp_lat;
    bit  got_done;
    int  bad_rows;
    lc = 0;
    for (int r = 0; r < ROWS; r++) lc += int'(m[r]);
    wp = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!m[r]) begin
        exp_board[wp] = mem[r];
        if (lc != 0) exp_q.push_back('{addr: ROW_W'(wp), data: mem[r]});
        wp--;
      end
    end
    for (int a = wp; a >= 0; a--) begin
      exp_board[a] = '0;
      exp_q.push_back('{addr: ROW_W'(a), data: '0});
    end
    exp_lat = (lc == 0) ? 1 : ROWS + 2 + lc;

    @(negedge clock);
    rd_cnt = 0;
    wr_cnt = 0;
    start = 1'b1;
    completed_lines = m;
    got_done = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL %s busy_after_start: got %b, required 1", name, busy);
        end
      end
      if (disturb && k == 3) begin
        start = 1'b1;
        completed_lines = ~m;
      end
      if (disturb && k == 4) start = 1'b0;
      if (abort_at > 0 && k == abort_at) begin
        tests++;
        if ({busy, wr_en} !== 2'b11) begin
          fails++;
          $display("FAIL %s fill_before_reset: got busy %b wr_en %b, required 1 1", name, busy, wr_en);
        end
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if ({busy, done, wr_en, rd_en} !== 4'b0000) begin
          fails++;
          $display("FAIL %s after_reset: got busy %b done %b wr_en %b rd_en %b, required all 0",
                   name, busy, done, wr_en, rd_en);
        end
        tests++;
        if (lines_cleared !== '0) begin
          fails++;
          $display("FAIL %s lines_after_reset: got %0d, required 0", name, lines_cleared);
        end
`ifdef LINE_CLEAR_SCORE_EN
        exp_score = '0;
        tests++;
        if (score !== exp_score) begin
          fails++;
          $display("FAIL %s score_after_reset: got %0d, required 0", name, score);
        end
`endif
        reset = 1'b0;
        exp_q.delete();
        return;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        lat = k;
        break;
      end
    end

    tests++;
    if (!got_done) begin
      fails++;
      $display("FAIL %s done_timeout: got no done in 200 cycles, required done after %0d", name, exp_lat);
      exp_q.delete();
      return;
    end
    tests++;
    if (lat != exp_lat) begin
      fails++;
      $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
    end
    tests++;
    if (lines_cleared !== ROW_W'(lc)) begin
      fails++;
      $display("FAIL %s lines_cleared: got %0d, required %0d", name, lines_cleared, lc);
    end
    tests++;
    if (rd_cnt != ((lc == 0) ? 0 : ROWS - lc) || wr_cnt != ((lc == 0) ? 0 : ROWS)) begin
      fails++;
      $display("FAIL %s access_count: got %0d reads %0d writes, required %0d reads %0d writes",
               name, rd_cnt, wr_cnt, (lc == 0) ? 0 : ROWS - lc, (lc == 0) ? 0 : ROWS);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s missing_writes: got %0d writes left over, required 0", name, exp_q.size());
      exp_q.delete();
    end
    bad_rows = 0;
    for (int r = 0; r < ROWS; r++) if (mem[r] !== exp_board[r]) bad_rows++;
    tests++;
    if (bad_rows != 0) begin
      fails++;
      $display("FAIL %s board: got %0d wrong rows (row19 %h row18 %h row0 %h), required 0 (row19 %h row18 %h row0 %h)",
               name, bad_rows, mem[19], mem[18], mem[0], exp_board[19], exp_board[18], exp_board[0]);
    end

    @(negedge clock);
    tests++;
    if ({busy, done} !== 2'b00 || lines_cleared !== ROW_W'(lc)) begin
      fails++;
      $display("FAIL %s after_done: got busy %b done %b lines %0d, required 0 0 %0d",
               name, busy, done, lines_cleared, lc);
    end
`ifdef LINE_CLEAR_SCORE_EN
    exp_score = exp_score + score_for(lc);
    tests++;
    if (score !== exp_score) begin
      fails++;
      $display("FAIL %s score: got %0d, required %0d", name, score, exp_score);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if ({busy, done, rd_en, wr_en} !== 4'b0000 || lines_cleared !== '0 ||
        rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      fails++;
      $display("FAIL reset_state: got busy %b done %b rd_en %b wr_en %b lines %0d rd_addr %0d wr_addr %0d wr_data %h, required all 0",
               busy, done, rd_en, wr_en, lines_cleared, rd_addr, wr_addr, wr_data);
    end
`ifdef LINE_CLEAR_SCORE_EN
    tests++;
    if (score !== '0) begin
      fails++;
      $display("FAIL reset_score: got %0d, required 0", score);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_zero_mask();
    load_board(1);
    run_pass("zero_mask", '0, 1'b0, 0);
  endtask

  task automatic test_two_lines();
    load_board(2);
    load_row(17, 10'h3FF);
    load_row(18, 10'h155);
    load_row(19, 10'h3FF);
    run_pass("two_lines", 20'h A0000, 1'b0, 0);
  endtask

  task automatic test_four_lines();
    load_board(3);
    run_pass("four_lines", 20'hF0000, 1'b0, 0);
  endtask

  task automatic test_all_ones();
    load_board(4);
    run_pass("all_ones", 20'hFFFFF, 1'b0, 0);
  endtask

  task automatic test_ignore_mid_pass();
    load_board(5);
    run_pass("ignore_mid", 20'h01020, 1'b1, 0);
  endtask

  task automatic test_reset_in_fill();
    load_board(6);
    run_pass("reset_fill", 20'h00808, 1'b0, 22);
    load_board(7);
    run_pass("after_reset", 20'h40101, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [ROWS-1:0] m;
    for (int i = 0; i < 3; i++) begin
      m = ROWS'($urandom_range(0, 20'hFFFFF));
      run_pass("back_to_back", m, 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_zero_mask();
    test_two_lines();
    test_four_lines();
    test_all_ones();
    test_ignore_mid_pass();
    test_reset_in_fill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
